// File: rtl/reset_sequencer.sv
// Multi-channel reset sequencer: holds NUM_CH reset lines until an initiate edge,
// waits a hold interval, then releases channels one by one starting at channel 0.
module reset_sequencer #(
  parameter int NUM_CH         = 4,
  parameter int HOLD_CYCLES    = 16,
  parameter int STAGGER_CYCLES = 4,
  parameter int CNT_W          = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              initiate,
  input  logic              rearm,
  output logic [NUM_CH-1:0] ch_reset,
  output logic              busy,
  output logic              done
);

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_RELEASE,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]  r_idx;
  logic              r_initiate_q;
  logic [NUM_CH-1:0] r_ch_reset;
  logic              r_busy;
  logic              r_done;

  logic              w_go;
  logic [NUM_CH-1:0] w_idx_mask;

  // initiate_q resets to 1 so a level held high through reset never counts as an edge
  assign w_go       = initiate & ~r_initiate_q;
  assign w_idx_mask = NUM_CH'(1) << r_idx;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_idx        <= '0;
      r_initiate_q <= 1'b1;
      r_ch_reset   <= '1;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_initiate_q <= initiate;
      if (rearm) begin
        r_state    <= S_IDLE;
        r_cnt      <= '0;
        r_idx      <= '0;
        r_ch_reset <= '1;
        r_busy     <= 1'b0;
        r_done     <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_ch_reset <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            if (w_go) begin
              r_state <= S_HOLD;
              r_cnt   <= '0;
              r_busy  <= 1'b1;
            end
          end
          S_HOLD: begin
            if (r_cnt == HOLD_LAST) begin
              r_ch_reset[0] <= 1'b0;
              r_cnt         <= '0;
              r_idx         <= IDX_W'(1);
              if (NUM_CH == 1) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end else begin
                r_state <= S_RELEASE;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_RELEASE: begin
            if (r_cnt == STAGGER_LAST) begin
              r_ch_reset <= r_ch_reset & ~w_idx_mask;
              r_cnt      <= '0;
              r_idx      <= r_idx + IDX_W'(1);
              // done rises on the same edge that frees the last channel
              if (r_idx == LAST_IDX) begin
                r_state <= S_DONE;
                r_busy  <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_W'(1);
            end
          end
          S_DONE: begin
            r_ch_reset <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b1;
          end
          default: begin
            r_state    <= S_IDLE;
            r_ch_reset <= '1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ch_reset = r_ch_reset;
  assign busy     = r_busy;
  assign done     = r_done;

`ifndef SYNTHESIS
  // Counter must be wide enough that neither interval can wrap it
  a_cnt_width : assert property (@(posedge clk)
    (HOLD_CYCLES < (1 << CNT_W)) && (STAGGER_CYCLES < (1 << CNT_W)));

  // Released channels always form a contiguous run starting at bit 0
  a_release_order : assert property (@(posedge clk) disable iff (reset)
    ((~r_ch_reset) & ((~r_ch_reset) + NUM_CH'(1))) == '0);
`endif

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: three configurations share one stimulus stream and are
// compared every cycle against a timing model derived from the release schedule.
module tb_reset_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       initiate;
  logic       rearm;
  logic [3:0] chA;
  logic       busyA, doneA;
  logic [0:0] chB;
  logic       busyB, doneB;
  logic [2:0] chC;
  logic       busyC, doneC;

  reset_sequencer #(.NUM_CH(4), .HOLD_CYCLES(16), .STAGGER_CYCLES(4), .CNT_W(8)) uA (
    .clk(clk), .reset(reset), .initiate(initiate), .rearm(rearm),
    .ch_reset(chA), .busy(busyA), .done(doneA));

  reset_sequencer #(.NUM_CH(1), .HOLD_CYCLES(1), .STAGGER_CYCLES(1), .CNT_W(8)) uB (
    .clk(clk), .reset(reset), .initiate(initiate), .rearm(rearm),
    .ch_reset(chB), .busy(busyB), .done(doneB));

  reset_sequencer #(.NUM_CH(3), .HOLD_CYCLES(5), .STAGGER_CYCLES(2), .CNT_W(4)) uC (
    .clk(clk), .reset(reset), .initiate(initiate), .rearm(rearm),
    .ch_reset(chC), .busy(busyC), .done(doneC));

  int nCh[3]     = '{4, 1, 3};
  int hold[3]    = '{16, 1, 5};
  int stagger[3] = '{4, 1, 2};

  bit active[3];
  int t0[3];
  bit prevInit[3];
  int cyc = 0;
  int checks = 0;
  int passes = 0;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, actual, expected, cyc);
  endtask

  // Number of channels released so far, from the schedule T0+H+k*S
  function automatic int released(input int i);
    int e;
    int r;
    e = cyc - t0[i];
    if (e < hold[i]) return 0;
    r = 1 + (e - hold[i]) / stagger[i];
    return (r > nCh[i]) ? nCh[i] : r;
  endfunction

  function automatic int expCh(input int i);
    int all;
    all = (1 << nCh[i]) - 1;
    if (!active[i]) return all;
    return all & ~((1 << released(i)) - 1);
  endfunction

  function automatic int expBusy(input int i);
    return (active[i] && released(i) < nCh[i]) ? 1 : 0;
  endfunction

  function automatic int expDone(input int i);
    return (active[i] && released(i) == nCh[i]) ? 1 : 0;
  endfunction

  task automatic modelUpdate();
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        active[i]   = 1'b0;
        prevInit[i] = 1'b1;
      end else if (rearm) begin
        active[i]   = 1'b0;
        prevInit[i] = initiate;
      end else begin
        if (!active[i] && initiate && !prevInit[i]) begin
          active[i] = 1'b1;
          t0[i]     = cyc;
        end
        prevInit[i] = initiate;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    cyc++;
    modelUpdate();
    #1;
    checkOutput("chA",   32'(chA),   32'(expCh(0)));
    checkOutput("busyA", 32'(busyA), 32'(expBusy(0)));
    checkOutput("doneA", 32'(doneA), 32'(expDone(0)));
    checkOutput("chB",   32'(chB),   32'(expCh(1)));
    checkOutput("busyB", 32'(busyB), 32'(expBusy(1)));
    checkOutput("doneB", 32'(doneB), 32'(expDone(1)));
    checkOutput("chC",   32'(chC),   32'(expCh(2)));
    checkOutput("busyC", 32'(busyC), 32'(expBusy(2)));
    checkOutput("doneC", 32'(doneC), 32'(expDone(2)));
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic i, input logic a, input int n);
    reset    = r;
    initiate = i;
    rearm    = a;
    repeat (n) stepCycle();
  endtask

  initial begin
    reset    = 1'b1;
    initiate = 1'b0;
    rearm    = 1'b0;

    // Power-up sequence; initiate edge sampled at T0
    applyStimulus(1, 0, 0, 3);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("s1_chB_T0+1", 32'(chB), 32'h0);
    checkOutput("s1_doneB_T0+1", 32'(doneB), 32'h1);
    applyStimulus(0, 1, 0, 14);
    checkOutput("s1_chA_T0+15", 32'(chA), 32'hF);
    applyStimulus(0, 1, 0, 1);
    checkOutput("s1_chA_T0+16", 32'(chA), 32'hE);
    applyStimulus(0, 1, 0, 11);
    checkOutput("s1_busyA_T0+27", 32'(busyA), 32'h1);
    applyStimulus(0, 1, 0, 1);
    checkOutput("s1_chA_T0+28", 32'(chA), 32'h0);
    checkOutput("s1_doneA_T0+28", 32'(doneA), 32'h1);

    // initiate held high through reset: no edge, nothing starts
    applyStimulus(1, 1, 0, 3);
    applyStimulus(0, 1, 0, 50);
    checkOutput("s2_chA_held", 32'(chA), 32'hF);
    checkOutput("s2_busyA_held", 32'(busyA), 32'h0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 30);

    // rearm at T0+22 after ch0/ch1 released, then a fresh start
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 22);
    applyStimulus(0, 1, 1, 1);
    checkOutput("s3_chA_rearm", 32'(chA), 32'hF);
    checkOutput("s3_doneA_rearm", 32'(doneA), 32'h0);
    applyStimulus(0, 1, 0, 5);
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 0, 17);
    checkOutput("s3_chA_T1+16", 32'(chA), 32'hE);
    applyStimulus(0, 1, 0, 15);

    // Extra initiate edges mid-sequence must not disturb the schedule
    applyStimulus(1, 0, 0, 2);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 4);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 0, 0, 12);
    applyStimulus(0, 1, 0, 1);
    applyStimulus(0, 1, 0, 12);
    checkOutput("s4_chA_done", 32'(chA), 32'h0);

    // rearm and go together in DONE: rearm wins
    applyStimulus(0, 0, 0, 2);
    applyStimulus(0, 1, 1, 1);
    applyStimulus(0, 1, 0, 5);
    checkOutput("s5_busyA_idle", 32'(busyA), 32'h0);
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 30);

    // Synchronous reset at T0+25
    applyStimulus(0, 0, 0, 1);
    applyStimulus(0, 1, 0, 25);
    applyStimulus(1, 1, 0, 1);
    checkOutput("s6_chA_reset", 32'(chA), 32'hF);
    applyStimulus(0, 1, 0, 5);

    // Randomised traffic
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 99) == 0);
      rearm = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 5) == 0) initiate = ~initiate;
      stepCycle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
